// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC.
// Rotates (x, y) toward the positive x axis one micro-rotation per clock,
// accumulating the applied rotation as an angle. Result: angle = atan2(y, x)
// in binary angle units (2^WIDTH = 360 deg) and mag = |v| * K (no gain
// compensation; K ~= 1.64676 at ITER=16).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         request, accepted only while idle
//   x_in, y_in    signed Cartesian input
//   busy          high while iterating
//   done          one-cycle pulse when mag/angle are updated
//   mag, angle    results, held until the next done
module cordic_vectoring_iter #(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH:0]          mag,
  output logic [WIDTH-1:0]        angle
);

  // Two guard bits: |v|*K stays below 2.33 * 2^(WIDTH-1), including the
  // negation of the most negative x_in.
  localparam int IW = WIDTH + 2;
  localparam logic [4:0] LAST = 5'(ITER - 1);

  // The arctangent table is held exactly for a 32-bit angle and rescaled
  // (with rounding) to the configured WIDTH.
  localparam int SH_L = (WIDTH > 32) ? WIDTH - 32 : 0;
  localparam int SH_R = (WIDTH < 32) ? 32 - WIDTH : 0;
  localparam logic [63:0] HALF = (64'd1 << SH_R) >> 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nx;
  logic signed [IW-1:0]  x, y, x_nx, y_nx, xs, ys;
  logic [WIDTH-1:0]      z, z_nx, at;
  logic [4:0]            cnt;
  logic                  zflag;
  logic signed [IW-1:0]  xe, ye;

  function automatic logic [WIDTH-1:0] atan_lut(input logic [4:0] i);
    logic [63:0] b;
    logic [63:0] s;
    case (i)
      5'd0:  b = 64'd536870912;
      5'd1:  b = 64'd316933406;
      5'd2:  b = 64'd167458907;
      5'd3:  b = 64'd85004756;
      5'd4:  b = 64'd42667331;
      5'd5:  b = 64'd21354465;
      5'd6:  b = 64'd10679838;
      5'd7:  b = 64'd5340245;
      5'd8:  b = 64'd2670163;
      5'd9:  b = 64'd1335087;
      5'd10: b = 64'd667544;
      5'd11: b = 64'd333772;
      5'd12: b = 64'd166886;
      5'd13: b = 64'd83443;
      5'd14: b = 64'd41722;
      5'd15: b = 64'd20861;
      5'd16: b = 64'd10430;
      5'd17: b = 64'd5215;
      5'd18: b = 64'd2608;
      5'd19: b = 64'd1304;
      5'd20: b = 64'd652;
      5'd21: b = 64'd326;
      5'd22: b = 64'd163;
      5'd23: b = 64'd81;
      5'd24: b = 64'd41;
      5'd25: b = 64'd20;
      5'd26: b = 64'd10;
      5'd27: b = 64'd5;
      5'd28: b = 64'd3;
      5'd29: b = 64'd1;
      5'd30: b = 64'd1;
      default: b = 64'd0;
    endcase
    s = ((b << SH_L) + HALF) >> SH_R;
    return s[WIDTH-1:0];
  endfunction

  // Sign-extended inputs for the accept edge.
  assign xe = {{2{x_in[WIDTH-1]}}, x_in};
  assign ye = {{2{y_in[WIDTH-1]}}, y_in};

  // One micro-rotation from the current (pre-update) values.
  always_comb begin
    xs = x >>> cnt;
    ys = y >>> cnt;
    at = atan_lut(cnt);
    if (!y[IW-1]) begin
      x_nx = x + ys;
      y_nx = y - xs;
      z_nx = z + at;
    end else begin
      x_nx = x - ys;
      y_nx = y + xs;
      z_nx = z - at;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (cnt == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      z     <= '0;
      cnt   <= '0;
      zflag <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      mag   <= '0;
      angle <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          // Fold the left half-plane into the right by a 180 deg pre-rotation.
          if (x_in[WIDTH-1]) begin
            x <= -xe;
            y <= -ye;
            z <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            x <= xe;
            y <= ye;
            z <= '0;
          end
          zflag <= (x_in == '0) && (y_in == '0);
          cnt   <= '0;
          busy  <= 1'b1;
        end
        RUN: begin
          x   <= x_nx;
          y   <= y_nx;
          z   <= z_nx;
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            mag   <= x_nx[WIDTH:0];
            angle <= zflag ? '0 : z_nx;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
module tb_cordic_vectoring_iter;
  localparam int WIDTH = 32;
  localparam int ITER  = 16;
  localparam real PI   = 3.14159265358979323846;
  localparam real FULL = 4294967296.0;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic signed [WIDTH-1:0] x_in = '0;
  logic signed [WIDTH-1:0] y_in = '0;
  logic                    busy, done;
  logic [WIDTH:0]          mag;
  logic [WIDTH-1:0]        angle;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  real kgain;

  cordic_vectoring_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .mag(mag), .angle(angle)
  );

  always #5 clk = ~clk;

  // ---- behavioural model: transaction timing and the held operands ----
  int                      m_cnt  = 0;
  bit                      m_done = 1'b0;
  bit                      m_have = 1'b0;
  logic signed [WIDTH-1:0] cur_x = '0, cur_y = '0, hx = '0, hy = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_have <= 1'b0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (start) begin
        cur_x <= x_in;
        cur_y <= y_in;
        m_cnt <= ITER;
      end
    end else begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_have <= 1'b1;
        hx     <= cur_x;
        hy     <= cur_y;
      end
    end
  end

  function automatic real ideal_ang(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y);
    real a;
    a = $atan2(real'(y), real'(x));
    if (a < 0.0) a = a + 2.0 * PI;
    return a / (2.0 * PI) * FULL;
  endfunction

  function automatic real ang_err(input logic [WIDTH-1:0] act, input real exp);
    real d;
    d = real'(act) - exp;
    while (d >  FULL / 2.0) d = d - FULL;
    while (d < -FULL / 2.0) d = d + FULL;
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic real ideal_mag(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] y);
    real rx, ry;
    rx = real'(x);
    ry = real'(y);
    return $sqrt(rx * rx + ry * ry) * kgain;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0b, want %0b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input real act, input real exp, input real tol);
    real d;
    tests++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      fails++;
      $display("FAIL %s at %0t: got %0.1f, want %0.1f +/- %0.1f", nm, $time, act, exp, tol);
    end
  endtask

  task automatic chk_ang(input string nm, input logic [WIDTH-1:0] act, input real exp);
    tests++;
    if (ang_err(act, exp) > 131072.0) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%08h, want ~%0.0f +/- 131072", nm, $time, act, exp);
    end
  endtask

  // ---- compare process: every cycle, away from the active edge ----
  always @(negedge clk) begin
    if (chk_on) begin
      chk_bit("busy", busy, (m_cnt != 0));
      chk_bit("done", done, m_done);
      if (!m_have || (hx == 0 && hy == 0)) begin
        chk_near("mag_zero", real'(mag), 0.0, 0.0);
        chk_near("angle_zero", real'(angle), 0.0, 0.0);
      end else begin
        chk_near("mag", real'(mag), ideal_mag(hx, hy), ideal_mag(hx, hy) / 16384.0 + 4.0);
        chk_ang("angle", angle, ideal_ang(hx, hy));
      end
    end
  end

  // Random operand, occasionally scaled down, keeping the vector away from the origin.
  task automatic rand_vec(output logic signed [WIDTH-1:0] x, output logic signed [WIDTH-1:0] y);
    do begin
      x = $signed($urandom) >>> $urandom_range(0, 10);
      y = $signed($urandom) >>> $urandom_range(0, 10);
    end while ((x > -(1 <<< 20) && x < (1 <<< 20)) && (y > -(1 <<< 20) && y < (1 <<< 20)));
  endtask

  // One transaction: 1-cycle start, bounded wait for done, latency check.
  task automatic run_one(input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                         input bit repulse);
    int n;
    logic signed [WIDTH-1:0] rx, ry;
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < ITER + 10) begin
      @(posedge clk); #1;
      n++;
      if (repulse && n == 5) begin
        rand_vec(rx, ry);
        x_in  = rx;
        y_in  = ry;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk_near("latency", real'(n), real'(ITER), 0.0);
  endtask

  initial begin
    logic signed [WIDTH-1:0] rx, ry;
    kgain = 1.0;
    for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    @(posedge clk); #1;
    chk_near("reset_mag", real'(mag), 0.0, 0.0);
    chk_near("reset_angle", real'(angle), 0.0, 0.0);
    chk_bit("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Directed points with hand-computed expectations.
    run_one(1000000, 0, 0);
    chk_near("lit_0deg_mag", real'(mag), 1646760.0, 110.0);
    chk_ang("lit_0deg_ang", angle, 0.0);
    run_one(0, 1000000, 0);
    chk_near("lit_90deg_mag", real'(mag), 1646760.0, 110.0);
    chk_ang("lit_90deg_ang", angle, 1073741824.0);
    run_one(-1000000, 0, 0);
    chk_near("lit_180deg_mag", real'(mag), 1646760.0, 110.0);
    chk_ang("lit_180deg_ang", angle, 2147483648.0);
    run_one(1000000, 1000000, 0);
    chk_near("lit_45deg_mag", real'(mag), 2328870.0, 150.0);
    chk_ang("lit_45deg_ang", angle, 536870912.0);
    run_one(32'sh80000000, 32'sh80000000, 0);
    chk_near("lit_225deg_mag", real'(mag), 5001200000.0, 310000.0);
    chk_bit("lit_225deg_bit32", mag[WIDTH], 1'b1);
    chk_ang("lit_225deg_ang", angle, 2684354560.0);
    run_one(0, 0, 0);
    chk_near("lit_zero_mag", real'(mag), 0.0, 0.0);
    chk_near("lit_zero_ang", real'(angle), 0.0, 0.0);

    // start re-pulsed mid-run with different operands: ignored.
    run_one(-700000, 300000, 1);
    repeat (ITER + 3) @(posedge clk);
    #1;

    // Random single transactions with idle gaps.
    for (int t = 0; t < 12; t++) begin
      rand_vec(rx, ry);
      run_one(rx, ry, 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // start held high: back-to-back results, operands changing every cycle.
    start = 1'b1;
    for (int c = 0; c < 4 * (ITER + 1); c++) begin
      rand_vec(rx, ry);
      x_in = rx;
      y_in = ry;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (ITER + 3) @(posedge clk);
    #1;

    // Reset in the middle of a run.
    run_one(1000000, 0, 0);
    x_in  = 500000;
    y_in  = -500000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_bit("arst_busy", busy, 1'b0);
    chk_bit("arst_done", done, 1'b0);
    chk_near("arst_mag", real'(mag), 0.0, 0.0);
    chk_near("arst_ang", real'(angle), 0.0, 0.0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (ITER + 4) @(posedge clk);
    #1;
    run_one(-300000, -900000, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule

// File: doc/cordic_vectoring_iter.md
Name: cordic_vectoring_iter

Overview:
- Iterative vectoring-mode CORDIC; the inverse direction of the pipelined rotation stages.
- Takes a Cartesian vector (x, y) and drives y toward zero, accumulating the rotation angle.
- Returns the angle as atan2(y, x) in binary angle units, and the magnitude scaled by the CORDIC gain.
- Sits after the rotation datapath, e.g. for phase/magnitude recovery, behind a start/done handshake.

Parameters:
- WIDTH, 32: signed input width and angle output width.
- ITER, 16: number of micro-rotations; legal range 1..31.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only in IDLE.
- x_in  input  WIDTH  signed x component.
- y_in  input  WIDTH  signed y component.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results are valid.
- mag  output  WIDTH+1  unsigned magnitude × K (K≈1.64676 for ITER=16); held until next done.
- angle  output  WIDTH  binary angle, 2^WIDTH = 360°, 0x20000000 = 45° at WIDTH=32; held until next done.

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE, busy=0, done=0, mag=0, angle=0, iteration counter=0, internal x/y/z=0.
- States:
  - IDLE: start=1 → RUN.
  - RUN: counter==ITER-1 at the edge → IDLE with done=1.
  - No other states.
- Accept edge (IDLE & start):
  - Sign-extend x_in, y_in to WIDTH+2 bits.
  - If x_in<0: x=-x_in, y=-y_in, z=2^(WIDTH-1) (180°). Else: x=x_in, y=y_in, z=0.
  - Latch zero flag = (x_in==0 && y_in==0). Set counter=0, busy=1.
- Each RUN edge, i=counter:
  - If y>=0: x+=y>>>i; y-=x>>>i; z+=atan_i.
  - Else: x-=y>>>i; y+=x>>>i; z-=atan_i.
  - Shifts are arithmetic and use pre-update values. z wraps modulo 2^WIDTH.
- atan_i = round(atan(2^-i)·2^WIDTH/(2π)), from an internal constant table for i=0..30. i=0 gives 2^(WIDTH-3).
- Final edge (counter==ITER-1):
  - mag=low WIDTH+1 bits of the updated x (always non-negative).
  - angle=updated z, or 0 if the zero flag is set. mag is naturally 0 in that case.
  - busy=0, done=1 for exactly one cycle.
- Latency: done is high in the cycle beginning ITER edges after the accept edge. Throughput: one result per ITER+1 cycles minimum.
- start while busy: ignored, inputs not sampled, no queuing.
- start while done=1: accepted (state is IDLE); mag/angle keep the old values until the new done.
- Internal width WIDTH+2 is sufficient: worst case |v|·K < 2.33·2^(WIDTH-1), so no overflow, including x_in=-2^(WIDTH-1) negation.
- Reset mid-RUN: immediately to reset state; the partial result is discarded, no done pulse.
- No gain compensation in this block; the downstream consumer scales mag by 1/K.
- Accuracy (ITER=16, WIDTH=32):
  - angle within ±2^17 LSB of ideal.
  - mag within ±(ideal·2^-14 + 4) LSB.

Test Plan:
- x=1000000, y=0, start 1 cycle → done 16 cycles later, busy high in between. angle≈0x00000000, mag≈1646760.
- x=0, y=1000000 → angle≈0x40000000 (90°), mag≈1646760. Then x=-1000000, y=0 → angle≈0x80000000, mag≈1646760.
- x=y=1000000 → angle≈0x20000000, mag≈2328870. x=y=-2^31 → angle≈0xA0000000, mag≈5001200000 (no wrap; bit 32 set).
- x=y=0 → mag=0, angle=0 exactly. start re-pulsed mid-RUN → ignored, single done, result unchanged.
- start held high continuously → back-to-back results every 17 cycles. Outputs are stable between done pulses.
- rst_n low at iteration 8 → busy=done=mag=angle=0 asynchronously. No done afterwards. Next start yields a correct result.
